bus_arbiter: RTL and testbench

//  Sole owner of the shared 32-bit tri0 datapath bus. Arbitrates N_SRC bus drivers round-robin.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 39 +++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and default sizing for the bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        CIN_WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_N_SRC       = 8;
    localparam int DEF_CIN_IDX     = 0;
    localparam int DEF_MAX_BURST   = 4;
    localparam int DEF_CIN_TIMEOUT = 0;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin winner select starting at rr_ptr
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic           found;
    logic [IW:0]    sum;

    // Rotate a doubled request vector so rr_ptr lands at bit 0, take the
    // lowest set bit, then map the offset back to an absolute index mod N.
    always_comb begin
        rot   = {req, req} >> rr_ptr;
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IW'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IW-1:0];
        any = |req;
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner of the shared datapath bus with Cin sequencing
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_SRC       = DEF_N_SRC,
    parameter int CIN_IDX     = DEF_CIN_IDX,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int CIN_TIMEOUT = DEF_CIN_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         req,
    input  logic [N_SRC-1:0]         lock,
    input  logic                     cin_done,
    output logic [N_SRC-1:0]         write_en,
    output logic                     cin_get,
    output logic                     grant_valid,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     cin_timeout
);

    localparam int IW = $clog2(N_SRC);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = (CIN_TIMEOUT == 0) ? 1 : $clog2(CIN_TIMEOUT + 1);
    localparam logic [IW-1:0] CIN_ID = IW'(CIN_IDX);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    winner_q, winner_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [N_SRC-1:0] write_en_q, write_en_d;
    logic             cin_get_q, cin_get_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IW-1:0]    grant_id_q, grant_id_d;
    logic             cin_timeout_q, cin_timeout_d;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
        return (v == IW'(N_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_picker #(
        .N  (N_SRC),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        winner_d      = winner_q;
        burst_cnt_d   = burst_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        write_en_d    = '0;
        cin_get_d     = 1'b0;
        cin_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    winner_d = pick_idx;
                    if (pick_idx == CIN_ID) begin
                        state_d    = CIN_WAIT;
                        cin_get_d  = 1'b1;
                        wait_cnt_d = WW'(1);
                    end else begin
                        state_d     = GRANT;
                        write_en_d  = N_SRC'(1) << pick_idx;
                        burst_cnt_d = BW'(1);
                    end
                end
            end
            GRANT: begin
                if (!lock[winner_q] || !req[winner_q] || burst_cnt_q == BW'(MAX_BURST)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_idx(winner_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    write_en_d  = N_SRC'(1) << winner_q;
                end
            end
            CIN_WAIT: begin
                // Abort beats cin_done, and cin_done beats the timeout.
                if (!req[CIN_IDX]) begin
                    state_d    = IDLE;
                    rr_ptr_d   = next_idx(CIN_ID);
                    wait_cnt_d = '0;
                end else if (cin_done) begin
                    state_d     = GRANT;
                    write_en_d  = N_SRC'(1) << CIN_ID;
                    burst_cnt_d = BW'(1);
                    wait_cnt_d  = '0;
                end else if (CIN_TIMEOUT != 0 && wait_cnt_q == WW'(CIN_TIMEOUT)) begin
                    state_d       = IDLE;
                    rr_ptr_d      = next_idx(CIN_ID);
                    cin_timeout_d = 1'b1;
                    wait_cnt_d    = '0;
                end else begin
                    cin_get_d = 1'b1;
                    if (!(&wait_cnt_q)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_valid_d = |write_en_d;
        grant_id_d    = grant_valid_d ? winner_d : '0;
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            winner_q      <= '0;
            burst_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            write_en_q    <= '0;
            cin_get_q     <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            cin_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            winner_q      <= winner_d;
            burst_cnt_q   <= burst_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            write_en_q    <= write_en_d;
            cin_get_q     <= cin_get_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            cin_timeout_q <= cin_timeout_d;
        end
    end

    assign write_en    = write_en_q;
    assign cin_get     = cin_get_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign cin_timeout = cin_timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed self-check of bus_arbiter
module tb_bus_arbiter;

    localparam int N    = 8;
    localparam int CIN  = 0;
    localparam int MAXB = 4;
    localparam int TO   = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic         cin_done;
    logic [N-1:0] write_en;
    logic         cin_get;
    logic         grant_valid;
    logic [2:0]   grant_id;
    logic         cin_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: who owns the bus, what phase we are in, and the counters
    int   m_phase;   // 0 bus free, 1 source driving, 2 waiting on Cin
    int   m_owner;
    int   m_ptr;
    int   m_cnt;
    int   m_wait;
    logic m_to;

    bus_arbiter #(
        .N_SRC       (N),
        .CIN_IDX     (CIN),
        .MAX_BURST   (MAXB),
        .CIN_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .cin_done    (cin_done),
        .write_en    (write_en),
        .cin_get     (cin_get),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .cin_timeout (cin_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_wait = 0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int w;
        m_to = 1'b0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                if (w == CIN) begin m_phase = 2; m_wait = 1; end
                else begin m_phase = 1; m_cnt = 1; end
            end
        end else if (m_phase == 1) begin
            if (!lock[m_owner] || !req[m_owner] || m_cnt == MAXB) begin
                m_phase = 0;
                m_ptr = (m_owner + 1) % N;
            end else begin
                m_cnt++;
            end
        end else begin
            if (!req[CIN]) begin
                m_phase = 0; m_ptr = (CIN + 1) % N;
            end else if (cin_done) begin
                m_phase = 1; m_cnt = 1;
            end else if (m_wait == TO) begin
                m_phase = 0; m_ptr = (CIN + 1) % N; m_to = 1'b1;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_we;
        exp_we = (m_phase == 1) ? (N'(1) << m_owner) : '0;
        check("write_en", 32'(write_en), 32'(exp_we));
        check("cin_get", 32'(cin_get), 32'(m_phase == 2));
        check("grant_valid", 32'(grant_valid), 32'(m_phase == 1));
        check("grant_id", 32'(grant_id), (m_phase == 1) ? 32'(m_owner) : 32'd0);
        check("cin_timeout", 32'(cin_timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(write_en)), 32'd1);
        check("gv_eq_or", 32'(grant_valid), 32'(|write_en));
        check("get_no_we", 32'(cin_get && (write_en != 0)), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; req = '0; lock = '0; cin_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(write_en), 32'd0);
        check("rst_get", 32'(cin_get), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single request on source 2
        req = 8'b0000_0100;
        tick();
        check("t1_we", 32'(write_en), 32'h04);
        check("t1_id", 32'(grant_id), 32'd2);
        req = '0;
        tick();
        check("t1_idle", 32'(write_en), 32'h00);
        repeat (2) tick();

        // held requests 1,2,7 rotate with one idle cycle between grants
        req = 8'b1000_0110;
        repeat (14) tick();
        req = '0;
        repeat (2) tick();

        // locked burst capped at MAX_BURST
        req = 8'b0000_1000; lock = 8'b0000_1000;
        repeat (4) begin
            tick();
            check("t3_burst", 32'(write_en), 32'h08);
        end
        req = 8'b0001_1000;
        tick();
        check("t3_gap", 32'(write_en), 32'h00);
        req = 8'b0001_0000; lock = '0;
        tick();
        check("t3_next", 32'(write_en), 32'h10);
        req = '0;
        repeat (2) tick();

        // Cin handshake
        req = 8'h01;
        repeat (5) begin
            tick();
            check("t4_get", 32'(cin_get), 32'd1);
        end
        cin_done = 1'b1;
        tick();
        check("t4_we", 32'(write_en), 32'h01);
        check("t4_get_lo", 32'(cin_get), 32'd0);
        cin_done = 1'b0; req = '0;
        repeat (2) tick();

        // Cin timeout after TO waiting cycles, then abort by dropping req
        req = 8'h01;
        repeat (TO) tick();
        tick();
        check("t5_timeout", 32'(cin_timeout), 32'd1);
        check("t5_no_we", 32'(write_en), 32'd0);
        req = '0;
        repeat (2) tick();
        req = 8'h01;
        repeat (3) tick();
        req = '0;
        tick();
        check("t5_abort", 32'(cin_get), 32'd0);
        repeat (2) tick();

        // asynchronous reset in the middle of a burst
        req = 8'h08; lock = 8'h08;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        check("t6_we", 32'(write_en), 32'd0);
        check("t6_gv", 32'(grant_valid), 32'd0);
        check("t6_get", 32'(cin_get), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0; req = 8'hFF; lock = '0;
        tick();
        check("t6_restart", 32'(cin_get), 32'd1);
        req = 8'hFE;
        repeat (4) tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            req      = N'($urandom) & N'($urandom);
            lock     = N'($urandom) | N'($urandom);
            cin_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) req[CIN] = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
